// File: rtl/cfg_pkg.sv
// Shared opcode/state types and header field positions for the configuration register file.
package cfg_pkg;

    typedef enum logic [3:0] {
        OP_WR     = 4'd1,
        OP_RD     = 4'd2,
        OP_RST    = 4'd3,
        OP_LOCK   = 4'd4,
        OP_UNLOCK = 4'd5
    } cfg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_COMMIT,
        ST_PEND,
        ST_RESP
    } cfg_state_e;

    localparam int HDR_OP_MSB   = 7;
    localparam int HDR_OP_LSB   = 4;
    localparam int HDR_ADDR_MSB = 3;
    localparam int HDR_ADDR_LSB = 0;

    function automatic int data_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/cfg_byte_serializer.sv
// Sends one register snapshot as DATA_BYTES bytes, MSB first, over a valid/ready handshake.
module cfg_byte_serializer
    import cfg_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    output logic [7:0]        rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              last
);

    localparam int DATA_BYTES = data_bytes(DATA_W);
    localparam int SH_W       = 8 * DATA_BYTES;

    logic [SH_W-1:0] shift_q, shift_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            fire;

    assign fire      = valid_q & rsp_ready;
    assign last      = fire && (cnt_q == 2'd0);
    assign rsp_valid = valid_q;
    assign rsp_data  = shift_q[SH_W-1 -: 8];

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            shift_d = SH_W'(word);
            cnt_d   = 2'(DATA_BYTES - 1);
            valid_d = 1'b1;
        end else if (fire) begin
            // The final byte stays on rsp_data after the handshake.
            if (cnt_q == 2'd0) begin
                valid_d = 1'b0;
            end else begin
                shift_d = SH_W'({shift_q, 8'h00});
                cnt_d   = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/cfg_regfile.sv
// Framed byte-command decoder driving NUM_REGS config registers with lock, stall, restore and readback.
module cfg_regfile
    import cfg_pkg::*;
#(
    parameter int                         NUM_REGS    = 8,
    parameter int                         DATA_W      = 12,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL   = '0,
    parameter int                         TIMEOUT_CYC = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_REGS-1:0]          stall,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_q,
    output logic [NUM_REGS-1:0]          cfg_update,
    output logic [7:0]                   rsp_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [7:0]                   err_cnt
);

    localparam int          DATA_BYTES = data_bytes(DATA_W);
    localparam int          SH_W       = 8 * DATA_BYTES;
    localparam logic [31:0] TMO_LOAD   = 32'(TIMEOUT_CYC - 1);

    cfg_state_e        state_q, state_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q, lock_d;
    logic [NUM_REGS-1:0] upd_q, upd_d;
    logic [3:0]        addr_q, addr_d;
    logic [SH_W-1:0]   shadow_q, shadow_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [7:0]        err_q, err_d;

    cfg_op_e           hdr_op;
    logic [3:0]        hdr_addr;
    logic              hdr_addr_ok, pend_addr_ok;
    logic              pend_stall, pend_lock;
    logic [DATA_W-1:0] rd_word;
    logic              in_fire, err, do_write;
    logic              ser_load, ser_last;

    assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_DATA);
    assign in_fire    = in_valid & in_ready;
    assign hdr_op     = cfg_op_e'(in_data[HDR_OP_MSB:HDR_OP_LSB]);
    assign hdr_addr   = in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign cfg_update = upd_q;
    assign err_cnt    = err_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_q[g*DATA_W +: DATA_W] = regs_q[g];
    end

    always_comb begin
        hdr_addr_ok  = int'(hdr_addr) < NUM_REGS;
        pend_addr_ok = int'(addr_q) < NUM_REGS;
        rd_word      = '0;
        pend_stall   = 1'b0;
        pend_lock    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == 4'(i)) rd_word = regs_q[i];
            if (addr_q == 4'(i)) begin
                pend_stall = stall[i];
                pend_lock  = lock_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        lock_d   = lock_q;
        upd_d    = '0;
        addr_d   = addr_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        err      = 1'b0;
        do_write = 1'b0;
        ser_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    addr_d = hdr_addr;
                    case (hdr_op)
                        OP_WR: begin
                            state_d  = ST_DATA;
                            cnt_d    = 2'(DATA_BYTES - 1);
                            shadow_d = '0;
                            tmo_d    = TMO_LOAD;
                        end
                        OP_RD: begin
                            if (hdr_addr_ok) begin
                                ser_load = 1'b1;
                                state_d  = ST_RESP;
                            end else begin
                                err = 1'b1;
                            end
                        end
                        OP_RST: begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (!lock_q[i]) begin
                                    regs_d[i] = RESET_VAL[i*DATA_W +: DATA_W];
                                    upd_d[i]  = 1'b1;
                                end
                            end
                        end
                        OP_LOCK, OP_UNLOCK: begin
                            if (hdr_addr_ok) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (hdr_addr == 4'(i)) lock_d[i] = (hdr_op == OP_LOCK);
                                end
                            end else begin
                                err = 1'b1;
                            end
                        end
                        default: err = 1'b1;
                    endcase
                end
            end
            ST_DATA: begin
                if (in_fire) begin
                    shadow_d = SH_W'({shadow_q, in_data});
                    tmo_d    = TMO_LOAD;
                    if (cnt_q == 2'd0) state_d = ST_COMMIT;
                    else               cnt_d   = cnt_q - 2'd1;
                end else if (tmo_q == 32'd0) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (!pend_addr_ok || pend_lock) err = 1'b1;
                else if (pend_stall)            state_d = ST_PEND;
                else                            do_write = 1'b1;
            end
            ST_PEND: begin
                if (!pend_stall) begin
                    do_write = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (ser_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bits of the assembled frame above DATA_W are dropped here.
        if (do_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 4'(i)) begin
                    regs_d[i] = shadow_q[DATA_W-1:0];
                    upd_d[i]  = 1'b1;
                end
            end
        end

        err_d = (err && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            lock_q   <= '0;
            upd_q    <= '0;
            addr_q   <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            lock_q   <= lock_d;
            upd_q    <= upd_d;
            addr_q   <= addr_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    cfg_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (rd_word),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .last      (ser_last)
    );

endmodule

// File: tb/tb_cfg_regfile.sv
// Scoreboard bench for cfg_regfile: stimulus queues expected updates/readback bytes, a monitor checks them.
module tb_cfg_regfile;

    localparam int NR  = 8;
    localparam int DW  = 12;
    localparam int TMO = 40;
    localparam logic [NR*DW-1:0] RV = {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NR-1:0]    stall = '0;
    logic [NR*DW-1:0] cfg_q;
    logic [NR-1:0]    cfg_update;
    logic [7:0]       rsp_data;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [7:0]       err_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    bit tgl_en   = 1'b0;

    typedef struct {
        logic [NR-1:0]    mask;
        logic [NR*DW-1:0] cfg;
        int               due;
    } upd_t;

    upd_t       upd_exp[$];
    logic [7:0] rsp_exp[$];
    logic [DW-1:0] model [NR];

    cfg_regfile #(
        .NUM_REGS    (NR),
        .DATA_W      (DW),
        .RESET_VAL   (RV),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stall      (stall),
        .cfg_q      (cfg_q),
        .cfg_update (cfg_update),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #2;
        if (tgl_en) rsp_ready = ~rsp_ready;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    function automatic logic [DW-1:0] reg_of(input int idx);
        return cfg_q[idx*DW +: DW];
    endfunction

    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_upd(input logic [NR-1:0] mask, input int due);
        upd_t e;
        e.mask = mask;
        e.cfg  = model_vec();
        e.due  = due;
        upd_exp.push_back(e);
    endtask

    // Monitor: every update pulse and every presented readback byte is matched against the queues.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (cfg_update != '0) begin
                if (upd_exp.size() == 0) begin
                    check("upd_unexpected", cfg_update, 0);
                end else begin
                    upd_t e;
                    e = upd_exp.pop_front();
                    check("upd_mask", cfg_update, e.mask);
                    check("upd_cfg", cfg_q, e.cfg);
                    check("upd_cycle", cyc, e.due);
                end
            end
            if (rsp_valid) begin
                if (rsp_exp.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    check("rsp_byte", rsp_data, rsp_exp[0]);
                    if (rsp_ready) void'(rsp_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int n;
        for (int i = 0; i < NR; i++) model[i] = DW'(i);

        wait_neg(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cfg", cfg_q, model_vec());
        check("rst_err", err_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_update", cfg_update, 0);

        // Plain write, then one with excess MSBs that must be discarded.
        send_byte(8'h13, a); send_byte(8'h0A, a); send_byte(8'hBC, a);
        model[3] = 12'hABC;
        push_upd(8'h08, a + 1);
        @(negedge clk);
        check("commit_in_ready", in_ready, 0);
        wait_neg(2);
        check("wr_err", err_cnt, 0);
        send_byte(8'h13, a); send_byte(8'hFA, a); send_byte(8'hBC, a);
        push_upd(8'h08, a + 1);
        wait_neg(3);
        check("wr_trunc", reg_of(3), 12'hABC);

        // Stalled write held in PEND; other stall bits must not matter.
        stall[5] = 1'b1;
        send_byte(8'h15, a); send_byte(8'h01, a); send_byte(8'h23, a);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) stall[4] = 1'b1;
            if (k == 3) stall[4] = 1'b0;
            if (k > 0) check("pend_in_ready", in_ready, 0);
        end
        check("pend_hold", reg_of(5), 12'h005);
        stall[5] = 1'b0;
        model[5] = 12'h123;
        push_upd(8'h20, cyc + 1);
        wait_neg(3);
        check("pend_release", reg_of(5), 12'h123);
        check("pend_done_ready", in_ready, 1);

        // Lock blocks writes but survives restore; restore hits every unlocked register.
        send_byte(8'h12, a); send_byte(8'h07, a); send_byte(8'h77, a);
        model[2] = 12'h777;
        push_upd(8'h04, a + 1);
        wait_neg(2);
        send_byte(8'h42, a);
        send_byte(8'h12, a); send_byte(8'h0F, a); send_byte(8'hFF, a);
        wait_neg(3);
        check("lock_err", err_cnt, 1);
        check("lock_hold", reg_of(2), 12'h777);
        send_byte(8'h30, a);
        for (int i = 0; i < NR; i++) if (i != 2) model[i] = DW'(i);
        push_upd(8'hFB, a);
        wait_neg(2);
        check("restore_cfg", cfg_q, model_vec());
        send_byte(8'h52, a);

        // Readback with rsp_ready toggling every cycle.
        send_byte(8'h13, a); send_byte(8'h0A, a); send_byte(8'hBC, a);
        model[3] = 12'hABC;
        push_upd(8'h08, a + 1);
        wait_neg(2);
        rsp_exp.push_back(8'h0A);
        rsp_exp.push_back(8'hBC);
        tgl_en = 1'b1;
        send_byte(8'h23, a);
        @(negedge clk);
        check("rd_valid_lat", rsp_valid, 1);
        check("rd_in_ready", in_ready, 0);
        n = 0;
        while ((rsp_valid || rsp_exp.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_done", rsp_exp.size(), 0);
        tgl_en = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rd_idle_ready", in_ready, 1);

        // Reset in the middle of a write frame.
        send_byte(8'h14, a); send_byte(8'h07, a);
        @(negedge clk);
        rst = 1'b1;
        wait_neg(2);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = DW'(i);
        @(negedge clk);
        check("midrst_cfg", cfg_q, model_vec());
        check("midrst_err", err_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        wait_neg(3);
        check("midrst_no_write", reg_of(4), 12'h004);

        // Errors: out-of-range write, timeout, unknown opcode, out-of-range read.
        send_byte(8'h19, a); send_byte(8'h00, a); send_byte(8'h01, a);
        wait_neg(3);
        check("oob_wr_err", err_cnt, 1);
        check("oob_wr_cfg", cfg_q, model_vec());
        send_byte(8'h11, a); send_byte(8'h22, a);
        @(negedge clk);
        while (cyc < a + TMO - 1) @(negedge clk);
        check("tmo_early", err_cnt, 1);
        check("tmo_early_ready", in_ready, 1);
        @(negedge clk);
        check("tmo_fire", err_cnt, 2);
        check("tmo_reg1", reg_of(1), 12'h001);
        send_byte(8'hF0, a);
        wait_neg(2);
        check("bad_op_err", err_cnt, 3);
        send_byte(8'h29, a);
        wait_neg(2);
        check("oob_rd_err", err_cnt, 4);
        check("oob_rd_ready", in_ready, 1);

        wait_neg(3);
        check("upd_leftover", upd_exp.size(), 0);
        check("rsp_leftover", rsp_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
